// File: rtl/dr_mem_pfq.sv
// Prefetch request queue between the directory's drtomem_pfreq port and the memory pfreq port.
// Optional statistics counters are enabled by defining DR_MEM_PFQ_STATS_EN.
module dr_mem_pfq #(
    parameter int DEPTH            = 8,
    parameter int LINE_OFFSET_BITS = 6,
    parameter int NID_W            = 4,
    parameter int PADDR_W          = 40
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               drtomem_pfreq_valid,
    output logic               drtomem_pfreq_retry,
    input  logic [NID_W-1:0]   drtomem_pfreq_nid,
    input  logic [PADDR_W-1:0] drtomem_pfreq_paddr,
    input  logic               drtomem_req_valid,
    input  logic               drtomem_req_retry,
    input  logic [PADDR_W-1:0] drtomem_req_paddr,
    output logic               pfqtomem_valid,
    input  logic               pfqtomem_retry,
    output logic [NID_W-1:0]   pfqtomem_nid,
    output logic [PADDR_W-1:0] pfqtomem_paddr
`ifdef DR_MEM_PFQ_STATS_EN
    ,
    output logic [15:0]        pfq_dup_cnt,
    output logic [15:0]        pfq_drop_cnt,
    output logic [15:0]        pfq_cancel_cnt
`endif
);

    localparam int CNT_W  = $clog2(DEPTH + 1);
    localparam int LINE_W = PADDR_W - LINE_OFFSET_BITS;

    logic [NID_W-1:0]   nid_q   [DEPTH];
    logic [PADDR_W-1:0] paddr_q [DEPTH];
    logic [CNT_W-1:0]   count;
    logic               lock;

    logic [NID_W-1:0]   nid_d   [DEPTH];
    logic [PADDR_W-1:0] paddr_d [DEPTH];
    logic [CNT_W-1:0]   count_d;
    logic [DEPTH-1:0]   keep;
    logic               pop, in_fire, dem_fire;
    logic               dup_hit, cancel_hit, insert, full_drop;
    logic [LINE_W-1:0]  in_line, dem_line;
    int                 kept, wr;

    logic unused_req_offset;
    assign unused_req_offset = ^drtomem_req_paddr[LINE_OFFSET_BITS-1:0];

    // The directory is never back-pressured; retry only covers reset.
    assign drtomem_pfreq_retry = reset;

    assign pfqtomem_valid = (count != '0);
    assign pfqtomem_nid   = nid_q[0];
    assign pfqtomem_paddr = paddr_q[0];

    // NOTE: every variable gets a default at the top of always_comb so no latch is inferred.
    always_comb begin
        pop        = pfqtomem_valid && !pfqtomem_retry;
        in_fire    = drtomem_pfreq_valid && !drtomem_pfreq_retry;
        dem_fire   = drtomem_req_valid && !drtomem_req_retry;
        in_line    = drtomem_pfreq_paddr[PADDR_W-1:LINE_OFFSET_BITS];
        dem_line   = drtomem_req_paddr[PADDR_W-1:LINE_OFFSET_BITS];
        keep       = '0;
        dup_hit    = dem_fire && (in_line == dem_line);
        cancel_hit = 1'b0;
        kept       = 0;
        wr         = 0;

        // All decisions look at the cycle-start contents; the popping or locked head is exempt from cancel.
        for (int i = 0; i < DEPTH; i++) begin
            if (i < int'(count)) begin
                keep[i] = 1'b1;
                if (paddr_q[i][PADDR_W-1:LINE_OFFSET_BITS] == in_line)
                    dup_hit = 1'b1;
                if (dem_fire && paddr_q[i][PADDR_W-1:LINE_OFFSET_BITS] == dem_line
                        && !(i == 0 && (lock || pop))) begin
                    keep[i]    = 1'b0;
                    cancel_hit = 1'b1;
                end
            end
        end
        if (pop)
            keep[0] = 1'b0;

        insert = in_fire && !dup_hit;
        for (int i = 0; i < DEPTH; i++)
            kept += int'(keep[i]);
        full_drop = insert && (kept == DEPTH);
        if (full_drop) begin
            if (!lock) keep[0] = 1'b0;
            else       keep[1] = 1'b0;
        end

        // Compact survivors toward the head, then append the new request at the tail.
        for (int i = 0; i < DEPTH; i++) begin
            nid_d[i]   = nid_q[i];
            paddr_d[i] = paddr_q[i];
        end
        for (int i = 0; i < DEPTH; i++) begin
            if (keep[i]) begin
                nid_d[wr]   = nid_q[i];
                paddr_d[wr] = paddr_q[i];
                wr++;
            end
        end
        if (insert) begin
            nid_d[wr]   = drtomem_pfreq_nid;
            paddr_d[wr] = drtomem_pfreq_paddr;
            wr++;
        end
        count_d = CNT_W'(wr);
    end

    // NOTE: the storage array is reset because entry 0 drives the outputs, which must read zero after reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                nid_q[i]   <= '0;
                paddr_q[i] <= '0;
            end
            count <= '0;
            lock  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register updates from the same cycle-start state.
            nid_q   <= nid_d;
            paddr_q <= paddr_d;
            count   <= count_d;
            if (pop)
                lock <= 1'b0;
            else if (pfqtomem_valid && pfqtomem_retry)
                lock <= 1'b1;
        end
    end

`ifdef DR_MEM_PFQ_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            pfq_dup_cnt    <= '0;
            pfq_drop_cnt   <= '0;
            pfq_cancel_cnt <= '0;
        end else begin
            if (in_fire && dup_hit && pfq_dup_cnt != 16'hFFFF)
                pfq_dup_cnt <= pfq_dup_cnt + 16'd1;
            if (full_drop && pfq_drop_cnt != 16'hFFFF)
                pfq_drop_cnt <= pfq_drop_cnt + 16'd1;
            if (cancel_hit && pfq_cancel_cnt != 16'hFFFF)
                pfq_cancel_cnt <= pfq_cancel_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_dr_mem_pfq.sv
// Directed self-checking bench for dr_mem_pfq (DEPTH=4); stats checks compile in with DR_MEM_PFQ_STATS_EN.
module tb_dr_mem_pfq;

    localparam int DEPTH   = 4;
    localparam int NID_W   = 4;
    localparam int PADDR_W = 16;

    logic               clk = 1'b0;
    logic               reset;
    logic               drtomem_pfreq_valid;
    logic               drtomem_pfreq_retry;
    logic [NID_W-1:0]   drtomem_pfreq_nid;
    logic [PADDR_W-1:0] drtomem_pfreq_paddr;
    logic               drtomem_req_valid;
    logic               drtomem_req_retry;
    logic [PADDR_W-1:0] drtomem_req_paddr;
    logic               pfqtomem_valid;
    logic               pfqtomem_retry;
    logic [NID_W-1:0]   pfqtomem_nid;
    logic [PADDR_W-1:0] pfqtomem_paddr;
`ifdef DR_MEM_PFQ_STATS_EN
    logic [15:0] pfq_dup_cnt, pfq_drop_cnt, pfq_cancel_cnt;
`endif

    int checks   = 0;
    int failures = 0;

    dr_mem_pfq #(.DEPTH(DEPTH), .LINE_OFFSET_BITS(6), .NID_W(NID_W), .PADDR_W(PADDR_W)) dut (
        .clk                 (clk),
        .reset               (reset),
        .drtomem_pfreq_valid (drtomem_pfreq_valid),
        .drtomem_pfreq_retry (drtomem_pfreq_retry),
        .drtomem_pfreq_nid   (drtomem_pfreq_nid),
        .drtomem_pfreq_paddr (drtomem_pfreq_paddr),
        .drtomem_req_valid   (drtomem_req_valid),
        .drtomem_req_retry   (drtomem_req_retry),
        .drtomem_req_paddr   (drtomem_req_paddr),
        .pfqtomem_valid      (pfqtomem_valid),
        .pfqtomem_retry      (pfqtomem_retry),
        .pfqtomem_nid        (pfqtomem_nid),
        .pfqtomem_paddr      (pfqtomem_paddr)
`ifdef DR_MEM_PFQ_STATS_EN
        ,
        .pfq_dup_cnt         (pfq_dup_cnt),
        .pfq_drop_cnt        (pfq_drop_cnt),
        .pfq_cancel_cnt      (pfq_cancel_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [NID_W-1:0] nid, input logic [PADDR_W-1:0] paddr);
        drtomem_pfreq_valid = 1'b1;
        drtomem_pfreq_nid   = nid;
        drtomem_pfreq_paddr = paddr;
        step();
        drtomem_pfreq_valid = 1'b0;
    endtask

    task automatic demand(input logic [PADDR_W-1:0] paddr, input logic rty);
        drtomem_req_valid = 1'b1;
        drtomem_req_retry = rty;
        drtomem_req_paddr = paddr;
        step();
        drtomem_req_valid = 1'b0;
        drtomem_req_retry = 1'b0;
    endtask

    logic [PADDR_W-1:0] drain_exp [4] = '{16'h0000, 16'h0080, 16'h00C0, 16'h0100};

    initial begin
        reset               = 1'b1;
        drtomem_pfreq_valid = 1'b0;
        drtomem_pfreq_nid   = '0;
        drtomem_pfreq_paddr = '0;
        drtomem_req_valid   = 1'b0;
        drtomem_req_retry   = 1'b0;
        drtomem_req_paddr   = '0;
        pfqtomem_retry      = 1'b0;
        #1;
        check("retry_in_reset", 32'(drtomem_pfreq_retry), 32'd1);
        step();
        step();
        check("reset_valid", 32'(pfqtomem_valid), 32'd0);
        check("reset_nid", 32'(pfqtomem_nid), 32'd0);
        check("reset_paddr", 32'(pfqtomem_paddr), 32'd0);
        reset = 1'b0;
        #1;
        check("retry_after_reset", 32'(drtomem_pfreq_retry), 32'd0);

        // Two back-to-back pushes flow straight through with one cycle latency.
        drtomem_pfreq_valid = 1'b1;
        drtomem_pfreq_nid   = 4'd2;
        drtomem_pfreq_paddr = 16'h1000;
        step();
        check("t1_first_valid", 32'(pfqtomem_valid), 32'd1);
        check("t1_first_paddr", 32'(pfqtomem_paddr), 32'h1000);
        check("t1_first_nid", 32'(pfqtomem_nid), 32'd2);
        drtomem_pfreq_paddr = 16'h2040;
        step();
        drtomem_pfreq_valid = 1'b0;
        check("t1_second_paddr", 32'(pfqtomem_paddr), 32'h2040);
        check("t1_second_count", 32'(dut.count), 32'd1);
        step();
        check("t1_empty_valid", 32'(pfqtomem_valid), 32'd0);
        check("t1_empty_count", 32'(dut.count), 32'd0);

        // Same-line push is suppressed.
        pfqtomem_retry = 1'b1;
        push(4'd1, 16'h1000);
        push(4'd1, 16'h1010);
        check("t2_dup_count", 32'(dut.count), 32'd1);
        check("t2_dup_head", 32'(pfqtomem_paddr), 32'h1000);
`ifdef DR_MEM_PFQ_STATS_EN
        check("t2_dup_cnt", 32'(pfq_dup_cnt), 32'd1);
`endif
        pfqtomem_retry = 1'b0;
        step();
        check("t2_drained", 32'(pfqtomem_valid), 32'd0);

        // Full with a locked head: entry 1 is the victim.
        pfqtomem_retry = 1'b1;
        push(4'd3, 16'h0000);
        push(4'd3, 16'h0040);
        push(4'd3, 16'h0080);
        push(4'd3, 16'h00C0);
        check("t3_full_count", 32'(dut.count), 32'd4);
        push(4'd3, 16'h0100);
        check("t3_after_drop_count", 32'(dut.count), 32'd4);
        check("t3_locked_head", 32'(pfqtomem_paddr), 32'h0000);
`ifdef DR_MEM_PFQ_STATS_EN
        check("t3_drop_cnt", 32'(pfq_drop_cnt), 32'd1);
`endif
        pfqtomem_retry = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("t3_drain_valid%0d", i), 32'(pfqtomem_valid), 32'd1);
            check($sformatf("t3_drain_paddr%0d", i), 32'(pfqtomem_paddr), 32'(drain_exp[i]));
            step();
        end
        check("t3_drain_empty", 32'(pfqtomem_valid), 32'd0);

        // Demand cancel of a queued line; retried demands and the locked head are left alone.
        pfqtomem_retry = 1'b1;
        push(4'd4, 16'h0040);
        push(4'd4, 16'h0080);
        demand(16'h0088, 1'b0);
        check("t4_cancel_count", 32'(dut.count), 32'd1);
        check("t4_cancel_head", 32'(pfqtomem_paddr), 32'h0040);
`ifdef DR_MEM_PFQ_STATS_EN
        check("t4_cancel_cnt", 32'(pfq_cancel_cnt), 32'd1);
`endif
        demand(16'h0040, 1'b0);
        check("t4_locked_head_kept", 32'(dut.count), 32'd1);
        push(4'd4, 16'h0080);
        demand(16'h0080, 1'b1);
        check("t4_retried_demand", 32'(dut.count), 32'd2);

        // Pop of the head in the same cycle as a push of its line: push is a duplicate.
        pfqtomem_retry = 1'b0;
        push(4'd5, 16'h0040);
        check("t5_pop_dup_count", 32'(dut.count), 32'd1);
        check("t5_pop_dup_head", 32'(pfqtomem_paddr), 32'h0080);
        step();
        check("t5_empty", 32'(pfqtomem_valid), 32'd0);

        // Push matching a same-cycle demand line is dropped; demand on empty queue is harmless.
        drtomem_req_valid   = 1'b1;
        drtomem_req_paddr   = 16'h0200;
        drtomem_pfreq_valid = 1'b1;
        drtomem_pfreq_paddr = 16'h0208;
        step();
        drtomem_req_valid   = 1'b0;
        drtomem_pfreq_valid = 1'b0;
        check("t5_demand_dup", 32'(pfqtomem_valid), 32'd0);
`ifdef DR_MEM_PFQ_STATS_EN
        check("t5_dup_cnt", 32'(pfq_dup_cnt), 32'd3);
`endif

        // Reset mid-operation discards everything.
        pfqtomem_retry = 1'b1;
        push(4'd6, 16'h0300);
        push(4'd6, 16'h0340);
        push(4'd6, 16'h0380);
        check("t6_filled", 32'(dut.count), 32'd3);
        reset = 1'b1;
        #1;
        check("t6_retry_in_reset", 32'(drtomem_pfreq_retry), 32'd1);
        step();
        reset = 1'b0;
        #1;
        check("t6_valid_after_reset", 32'(pfqtomem_valid), 32'd0);
        check("t6_count_after_reset", 32'(dut.count), 32'd0);
        check("t6_retry_released", 32'(drtomem_pfreq_retry), 32'd0);
`ifdef DR_MEM_PFQ_STATS_EN
        check("t6_drop_cnt_reset", 32'(pfq_drop_cnt), 32'd0);
`endif
        push(4'd7, 16'h0400);
        check("t6_post_reset_paddr", 32'(pfqtomem_paddr), 32'h0400);
        check("t6_post_reset_nid", 32'(pfqtomem_nid), 32'd7);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
